counter_run_ctrl: RTL and testbench

Sequencer and round-robin arbiter for the shared up-counter (`ld`/`v`/`count` interface, reset loads `v`). Up to NREQ requesters each request a timed run of the counter from a start value for a given number of cycles. The block grants one run at a time. It drives the counter's `ld` and `v` to hold, preload and release it, watches `count` for the terminal value, and reports completion to the owning requester.

---
 rtl/counter_run_ctrl_if.sv | 24 ++
 rtl/counter_run_ctrl.sv | 74 +++++++
 tb/tb_counter_run_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_run_ctrl_if.sv
// counter_run_ctrl_if: requester and counter-side signals of the run sequencer.
interface counter_run_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_start;
    logic [NREQ*WIDTH-1:0] req_len;
    logic                  abort;
    logic [WIDTH-1:0]      ctr_count;
    logic                  ctr_ld;
    logic [WIDTH-1:0]      ctr_v;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    modport master (
        output req, req_start, req_len, abort, ctr_count,
        input  ctr_ld, ctr_v, gnt, done, busy
    );
    modport slave (
        input  req, req_start, req_len, abort, ctr_count,
        output ctr_ld, ctr_v, gnt, done, busy
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: round-robin arbiter that sequences timed runs of a shared up-counter.
module counter_run_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input logic              clk,
    input logic              rst,
    counter_run_ctrl_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [IW-1:0]    r_ptr, r_owner, w_win, w_idx, w_ptr_nxt;
    logic [WIDTH-1:0] r_end, w_start, w_len;
    logic [NREQ-1:0]  r_gnt;
    logic             w_found;
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end
    always_comb begin
        w_start = '0;
        w_len   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == w_win) begin
                w_start = bus.req_start[k*WIDTH +: WIDTH];
                w_len   = bus.req_len[k*WIDTH +: WIDTH];
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? RUN : IDLE;
            RUN:     w_next = bus.abort ? IDLE : (bus.ctr_count == r_end) ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end
    assign w_ptr_nxt = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
    // ctr_v is forced to 0 under rst so the counter, which resets by loading v, comes up at 0
    assign bus.ctr_ld = (r_state != RUN);
    assign bus.ctr_v  = (r_state == IDLE && w_found && !rst) ? w_start : '0;
    assign bus.gnt    = r_gnt;
    assign bus.done   = (r_state == DONE) ? (NREQ'(1) << r_owner) : '0;
    assign bus.busy   = (r_state != IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_end   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_owner <= w_win;
                r_end   <= w_start + w_len - 1'b1;
                r_gnt   <= NREQ'(1) << w_win;
            end
            if ((r_state == RUN && bus.abort) || r_state == DONE) begin
                r_ptr <= w_ptr_nxt;
                r_gnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: directed and randomized checks of the run sequencer against a timeline model.
module tb_counter_run_ctrl;
    localparam int W = 8;
    localparam int N = 4;
    localparam int M = 1 << W;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    counter_run_ctrl_if #(.WIDTH(W), .NREQ(N)) bus ();
    counter_run_ctrl #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [W-1:0] t_start [N];
    logic [W-1:0] t_len [N];
    logic [N-1:0] t_req;
    logic         t_abort;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_start[i*W +: W] = t_start[i];
            bus.req_len[i*W +: W]   = t_len[i];
        end
    end
    assign bus.req   = t_req;
    assign bus.abort = t_abort;
    // behavioural up-counter: rst or ld loads v, otherwise increments
    always @(posedge clk) bus.ctr_count <= (rst || bus.ctr_ld) ? bus.ctr_v : bus.ctr_count + 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // timeline model: a run granted at G occupies G+1..G+L (RUN) and G+L+1 (DONE)
    int m_active, m_owner, m_start, m_L, m_t, m_ptr, m_cnt, m_w;
    int e_busy, e_gnt, e_ld, e_done, e_v, e_cnt;
    initial begin
        m_active = 0;
        m_ptr = 0;
        @(posedge clk);
        m_cnt = 0;
        forever begin
            @(negedge clk);
            m_w = -1;
            for (int k = 0; k < N; k++)
                if (m_w < 0 && t_req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            e_busy = m_active;
            e_gnt  = m_active ? (1 << m_owner) : 0;
            e_ld   = (!m_active || m_t == m_L + 1) ? 1 : 0;
            e_done = (m_active && m_t == m_L + 1) ? (1 << m_owner) : 0;
            e_v    = (!m_active && m_w >= 0 && !rst) ? int'(t_start[m_w]) : 0;
            e_cnt  = m_active ? (m_start + m_t - 1) % M : m_cnt;
            chk("busy", bus.busy, e_busy);
            chk("gnt", bus.gnt, e_gnt);
            chk("ctr_ld", bus.ctr_ld, e_ld);
            chk("done", bus.done, e_done);
            chk("ctr_v", bus.ctr_v, e_v);
            chk("count", bus.ctr_count, e_cnt);
            @(posedge clk);
            m_cnt = (rst || e_ld != 0) ? e_v : (e_cnt + 1) % M;
            if (rst) begin
                m_active = 0;
                m_ptr = 0;
            end else if (!m_active) begin
                if (m_w >= 0) begin
                    m_active = 1;
                    m_owner = m_w;
                    m_start = t_start[m_w];
                    m_L = (t_len[m_w] == 0) ? M : int'(t_len[m_w]);
                    m_t = 1;
                end
            end else if ((m_t <= m_L && t_abort) || m_t == m_L + 1) begin
                m_active = 0;
                m_ptr = (m_owner + 1) % N;
            end else m_t++;
        end
    end
    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (c < budget) begin
            @(negedge clk);
            if (!bus.busy) break;
            tick();
            c++;
        end
        chk("idle_reached", bus.busy, 0);
    endtask
    int rr_idx[$];
    int rr_cyc[$];
    int exp_rr[5] = '{2, 3, 0, 1, 2};
    int c;
    logic [N-1:0] prev;
    initial begin
        t_abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            t_start[i] = '0;
            t_len[i] = 8'd1;
        end
        t_req = N'($urandom);
        tick();
        tick();
        rst = 1'b0;
        t_req = '0;
        @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ld", bus.ctr_ld, 1);
        chk("rst_v", bus.ctr_v, 0);
        chk("rst_count", bus.ctr_count, 0);
        tick();
        t_req = 4'b0010;
        t_start[1] = 8'd5;
        t_len[1] = 8'd3;
        @(negedge clk);
        chk("single_preload", bus.ctr_v, 5);
        tick();
        t_req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("single_count", bus.ctr_count, 5 + k);
            chk("single_gnt", bus.gnt, 4'b0010);
            tick();
        end
        @(negedge clk);
        chk("single_done", bus.done, 4'b0010);
        chk("single_overshoot", bus.ctr_count, 8);
        tick();
        @(negedge clk);
        chk("single_parked", bus.ctr_count, 0);
        tick();
        for (int i = 0; i < N; i++) begin
            t_len[i] = 8'd2;
            t_start[i] = W'($urandom);
        end
        t_req = 4'hF;
        prev = '0;
        for (int k = 0; k < 40 && rr_idx.size() < 5; k++) begin
            @(negedge clk);
            if (bus.gnt != 0 && prev == 0) begin
                rr_idx.push_back($clog2(bus.gnt));
                rr_cyc.push_back(k);
            end
            prev = bus.gnt;
            tick();
        end
        t_req = '0;
        chk("rr_runs", rr_idx.size(), 5);
        for (int i = 0; i < rr_idx.size(); i++) chk("rr_order", rr_idx[i], exp_rr[i]);
        for (int i = 1; i < rr_cyc.size(); i++) chk("rr_spacing", rr_cyc[i] - rr_cyc[i-1], 4);
        wait_idle(20);
        tick();
        t_req = 4'b1000;
        t_start[3] = 8'd250;
        t_len[3] = 8'd10;
        tick();
        t_req = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("wrap_count", bus.ctr_count, (250 + k) % M);
            tick();
        end
        @(negedge clk);
        chk("wrap_done", bus.done, 4'b1000);
        tick();
        t_req = 4'b0001;
        t_start[0] = 8'd0;
        t_len[0] = 8'd0;
        tick();
        t_req = '0;
        c = 1;
        while (c < 300) begin
            @(negedge clk);
            if (bus.done[0]) break;
            tick();
            c++;
        end
        chk("len0_done_cycle", c, 257);
        tick();
        t_len[0] = 8'd3;
        t_req = 4'b0010;
        t_start[1] = 8'd0;
        t_len[1] = 8'd20;
        tick();
        t_req = '0;
        repeat (7) tick();
        t_abort = 1'b1;
        t_req = 4'b0110;
        @(negedge clk);
        chk("abort_at_count", bus.ctr_count, 7);
        tick();
        t_abort = 1'b0;
        @(negedge clk);
        chk("abort_gnt", bus.gnt, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        tick();
        @(negedge clk);
        chk("abort_next_owner", bus.gnt, 4'b0100);
        tick();
        t_req = '0;
        wait_idle(20);
        tick();
        t_req = 4'b1000;
        t_start[3] = 8'd0;
        t_len[3] = 8'd10;
        tick();
        t_req = '0;
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstrun_count", bus.ctr_count, 4);
        tick();
        rst = 1'b0;
        t_req = 4'b1001;
        @(negedge clk);
        chk("rstrun_busy", bus.busy, 0);
        chk("rstrun_gnt", bus.gnt, 0);
        chk("rstrun_count0", bus.ctr_count, 0);
        tick();
        t_req = '0;
        @(negedge clk);
        chk("rstrun_regrant", bus.gnt, 4'b0001);
        wait_idle(20);
        repeat (4000) begin
            tick();
            if ($urandom_range(0, 3) == 0) t_req = N'($urandom);
            t_abort = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    t_start[i] = W'($urandom);
                    t_len[i] = ($urandom_range(0, 49) == 0) ? 8'd0 : W'($urandom_range(1, 8));
                end
            end
        end
        tick();
        rst = 1'b0;
        t_abort = 1'b0;
        t_req = '0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
